// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller for a 5-stage MIPS pipeline.
// Converts hazard, multiply, data-memory and branch requests into
// pipeline-register enables, bubble/flush controls and a freeze signal,
// and keeps saturating stall/flush statistics.
module pipeline_stall_controller #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_WIDTH   = 3,
  parameter int PERF_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  HazardStall,
  input  logic [1:0]            HazardCycles,
  input  logic                  BranchTaken,
  input  logic                  MulStart,
  input  logic                  DMemStall,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Flush,
  output logic                  ControlMux,
  output logic                  ID_EX_Write,
  output logic                  ExBubble,
  output logic                  Freeze,
  output logic                  Busy,
  output logic [PERF_WIDTH-1:0] StallCount,
  output logic [PERF_WIDTH-1:0] FlushCount
);

  typedef enum logic [1:0] {
    RUN = 2'd0,
    HAZ = 2'd1,
    MUL = 2'd2
  } state_t;

  // Remaining cycles after the issue cycle of a multiply.
  localparam logic [CNT_WIDTH-1:0] MUL_INIT = CNT_WIDTH'(MUL_LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [CNT_WIDTH-1:0] haz_cycles_ext;

  assign haz_cycles_ext = CNT_WIDTH'(HazardCycles);

  // State and countdown register; an asserted reset aborts any stall.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and output decode; while reset is low the defaults are forced.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    ID_EX_Write = 1'b1;
    ControlMux  = 1'b1;
    IF_ID_Flush = 1'b0;
    ExBubble    = 1'b0;
    Freeze      = 1'b0;
    Busy        = 1'b0;
    if (Reset) begin
      Busy = (state_reg != RUN);
      if (DMemStall) begin
        // Whole-pipeline freeze: state and count hold so pending work resumes.
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Write = 1'b0;
        Freeze      = 1'b1;
      end else begin
        unique case (state_reg)
          RUN: begin
            if (MulStart) begin
              PCWrite     = 1'b0;
              IF_ID_Write = 1'b0;
              ID_EX_Write = 1'b0;
              ExBubble    = 1'b1;
              state_next  = MUL;
              cnt_next    = MUL_INIT;
            end else if (HazardStall) begin
              PCWrite     = 1'b0;
              IF_ID_Write = 1'b0;
              ControlMux  = 1'b0;
              // A request of 0 or 1 bubbles is a single-cycle stall.
              if (HazardCycles > 2'd1) begin
                state_next = HAZ;
                cnt_next   = haz_cycles_ext - CNT_ONE;
              end
            end else if (BranchTaken) begin
              IF_ID_Flush = 1'b1;
            end
          end
          HAZ: begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ControlMux  = 1'b0;
            cnt_next    = cnt_reg - CNT_ONE;
            if (cnt_reg == CNT_ONE) state_next = RUN;
          end
          MUL: begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Write = 1'b0;
            ExBubble    = 1'b1;
            cnt_next    = cnt_reg - CNT_ONE;
            if (cnt_reg == CNT_ONE) state_next = RUN;
          end
          default: begin
            state_next = RUN;
            cnt_next   = '0;
          end
        endcase
      end
    end
  end

  // Saturating statistics: stalled-PC cycles and IF/ID flush cycles.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (!PCWrite && (StallCount != {PERF_WIDTH{1'b1}}))
        StallCount <= StallCount + 1'b1;
      if (IF_ID_Flush && (FlushCount != {PERF_WIDTH{1'b1}}))
        FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed testbench for pipeline_stall_controller with hand-computed
// expectations; a second instance with 4-bit statistics checks saturation.
module tb_pipeline_stall_controller;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        HazardStall = 1'b0;
  logic [1:0]  HazardCycles = 2'd0;
  logic        BranchTaken = 1'b0;
  logic        MulStart = 1'b0;
  logic        DMemStall = 1'b0;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ControlMux;
  logic        ID_EX_Write, ExBubble, Freeze, Busy;
  logic [15:0] StallCount, FlushCount;
  logic        pc_write4, if_id_write4, if_id_flush4, control_mux4;
  logic        id_ex_write4, ex_bubble4, freeze4, busy4;
  logic [3:0]  stall_count4, flush_count4;

  int vectors = 0;
  int miscompares = 0;

  pipeline_stall_controller #(.MUL_LATENCY(4), .CNT_WIDTH(3), .PERF_WIDTH(16)) dut (
    .Clk(Clk), .Reset(Reset), .HazardStall(HazardStall), .HazardCycles(HazardCycles),
    .BranchTaken(BranchTaken), .MulStart(MulStart), .DMemStall(DMemStall),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ControlMux(ControlMux), .ID_EX_Write(ID_EX_Write), .ExBubble(ExBubble),
    .Freeze(Freeze), .Busy(Busy), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  pipeline_stall_controller #(.MUL_LATENCY(4), .CNT_WIDTH(3), .PERF_WIDTH(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .HazardStall(HazardStall), .HazardCycles(HazardCycles),
    .BranchTaken(BranchTaken), .MulStart(MulStart), .DMemStall(DMemStall),
    .PCWrite(pc_write4), .IF_ID_Write(if_id_write4), .IF_ID_Flush(if_id_flush4),
    .ControlMux(control_mux4), .ID_EX_Write(id_ex_write4), .ExBubble(ex_bubble4),
    .Freeze(freeze4), .Busy(busy4), .StallCount(stall_count4), .FlushCount(flush_count4)
  );

  always #5 Clk = ~Clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Clear inputs and pulse reset so each scenario starts with zeroed statistics.
  task automatic do_reset();
    HazardStall = 1'b0; HazardCycles = 2'd0; BranchTaken = 1'b0;
    MulStart = 1'b0; DMemStall = 1'b0;
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b0; HazardStall = 1'b1; HazardCycles = 2'd3; MulStart = 1'b0;
    #1;
    vectors++; if (PCWrite !== 1'b1) begin miscompares++; $display("FAIL rst_pcwrite: got %b want 1", PCWrite); end
    vectors++; if (ControlMux !== 1'b1) begin miscompares++; $display("FAIL rst_controlmux: got %b want 1", ControlMux); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", Busy); end
    tick();
    vectors++; if (IF_ID_Write !== 1'b1 || ID_EX_Write !== 1'b1) begin miscompares++; $display("FAIL rst_writes: got %b%b want 11", IF_ID_Write, ID_EX_Write); end
    HazardStall = 1'b0; HazardCycles = 2'd0;
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    vectors++; if (StallCount !== 16'd0) begin miscompares++; $display("FAIL rst_stallcount: got %0d want 0", StallCount); end
    vectors++; if (FlushCount !== 16'd0) begin miscompares++; $display("FAIL rst_flushcount: got %0d want 0", FlushCount); end
    $display("test_reset: StallCount=%0d FlushCount=%0d", StallCount, FlushCount);
  endtask

  task automatic test_hazard();
    do_reset();
    HazardStall = 1'b1; HazardCycles = 2'd2;
    #1;
    vectors++; if (PCWrite !== 1'b0) begin miscompares++; $display("FAIL haz_c1_pcwrite: got %b want 0", PCWrite); end
    vectors++; if (ControlMux !== 1'b0) begin miscompares++; $display("FAIL haz_c1_controlmux: got %b want 0", ControlMux); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL haz_c1_busy: got %b want 0", Busy); end
    tick();
    HazardStall = 1'b0; HazardCycles = 2'd0;
    #1;
    vectors++; if (PCWrite !== 1'b0) begin miscompares++; $display("FAIL haz_c2_pcwrite: got %b want 0", PCWrite); end
    vectors++; if (ControlMux !== 1'b0) begin miscompares++; $display("FAIL haz_c2_controlmux: got %b want 0", ControlMux); end
    vectors++; if (Busy !== 1'b1) begin miscompares++; $display("FAIL haz_c2_busy: got %b want 1", Busy); end
    tick();
    vectors++; if (PCWrite !== 1'b1) begin miscompares++; $display("FAIL haz_c3_pcwrite: got %b want 1", PCWrite); end
    vectors++; if (Busy !== 1'b0) begin miscompares++; $display("FAIL haz_c3_busy: got %b want 0", Busy); end
    vectors++; if (StallCount !== 16'd2) begin miscompares++; $display("FAIL haz_stallcount: got %0d want 2", StallCount); end
    // HazardCycles=0 behaves as a single bubble.
    HazardStall = 1'b1; HazardCycles = 2'd0;
    tick();
    HazardStall = 1'b0;
    #1;
    vectors++; if (PCWrite !== 1'b1 || Busy !== 1'b0) begin miscompares++; $display("FAIL haz0_after: got pcw=%b busy=%b want pcw=1 busy=0", PCWrite, Busy); end
    vectors++; if (StallCount !== 16'd3) begin miscompares++; $display("FAIL haz0_stallcount: got %0d want 3", StallCount); end
    $display("test_hazard: StallCount=%0d", StallCount);
  endtask

  task automatic test_mul();
    do_reset();
    MulStart = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      vectors++;
      if (PCWrite !== 1'b0 || ID_EX_Write !== 1'b0 || ExBubble !== 1'b1 || ControlMux !== 1'b1) begin
        miscompares++;
        $display("FAIL mul_c%0d: got pcw=%b idex=%b exb=%b cmux=%b want 0 0 1 1", c, PCWrite, ID_EX_Write, ExBubble, ControlMux);
      end
      tick();
      MulStart = 1'b0;
      HazardStall = (c == 1);
      HazardCycles = 2'd3;
    end
    HazardStall = 1'b0; HazardCycles = 2'd0;
    #1;
    vectors++; if (PCWrite !== 1'b1 || ExBubble !== 1'b0 || Busy !== 1'b0) begin miscompares++; $display("FAIL mul_done: got pcw=%b exb=%b busy=%b want 1 0 0", PCWrite, ExBubble, Busy); end
    vectors++; if (StallCount !== 16'd4) begin miscompares++; $display("FAIL mul_stallcount: got %0d want 4", StallCount); end
    $display("test_mul: StallCount=%0d", StallCount);
  endtask

  task automatic test_freeze();
    do_reset();
    MulStart = 1'b1;
    #1;
    vectors++; if (ExBubble !== 1'b1 || Freeze !== 1'b0) begin miscompares++; $display("FAIL frz_c1: got exb=%b frz=%b want 1 0", ExBubble, Freeze); end
    tick();
    MulStart = 1'b0; DMemStall = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      #1;
      vectors++;
      if (Freeze !== 1'b1 || ExBubble !== 1'b0 || PCWrite !== 1'b0 || ID_EX_Write !== 1'b0 || IF_ID_Write !== 1'b0) begin
        miscompares++;
        $display("FAIL frz_c%0d: got frz=%b exb=%b pcw=%b idex=%b ifid=%b want 1 0 0 0 0", c, Freeze, ExBubble, PCWrite, ID_EX_Write, IF_ID_Write);
      end
      tick();
    end
    DMemStall = 1'b0;
    for (int c = 5; c <= 7; c++) begin
      #1;
      vectors++;
      if (Freeze !== 1'b0 || ExBubble !== 1'b1 || PCWrite !== 1'b0) begin
        miscompares++;
        $display("FAIL frz_resume_c%0d: got frz=%b exb=%b pcw=%b want 0 1 0", c, Freeze, ExBubble, PCWrite);
      end
      tick();
    end
    #1;
    vectors++; if (PCWrite !== 1'b1 || Busy !== 1'b0) begin miscompares++; $display("FAIL frz_done: got pcw=%b busy=%b want 1 0", PCWrite, Busy); end
    vectors++; if (StallCount !== 16'd7) begin miscompares++; $display("FAIL frz_stallcount: got %0d want 7", StallCount); end
    $display("test_freeze: StallCount=%0d", StallCount);
  endtask

  task automatic test_branch();
    do_reset();
    BranchTaken = 1'b1;
    #1;
    vectors++; if (IF_ID_Flush !== 1'b1 || PCWrite !== 1'b1) begin miscompares++; $display("FAIL br_flush: got flush=%b pcw=%b want 1 1", IF_ID_Flush, PCWrite); end
    tick();
    BranchTaken = 1'b0;
    #1;
    vectors++; if (IF_ID_Flush !== 1'b0) begin miscompares++; $display("FAIL br_flush_off: got %b want 0", IF_ID_Flush); end
    vectors++; if (FlushCount !== 16'd1) begin miscompares++; $display("FAIL br_flushcount: got %0d want 1", FlushCount); end
    BranchTaken = 1'b1; HazardStall = 1'b1; HazardCycles = 2'd1;
    #1;
    vectors++; if (IF_ID_Flush !== 1'b0 || PCWrite !== 1'b0) begin miscompares++; $display("FAIL br_suppressed: got flush=%b pcw=%b want 0 0", IF_ID_Flush, PCWrite); end
    tick();
    BranchTaken = 1'b0; HazardStall = 1'b0; HazardCycles = 2'd0;
    #1;
    vectors++; if (IF_ID_Flush !== 1'b0) begin miscompares++; $display("FAIL br_not_remembered: got %b want 0", IF_ID_Flush); end
    vectors++; if (FlushCount !== 16'd1 || StallCount !== 16'd1) begin miscompares++; $display("FAIL br_counts: got flush=%0d stall=%0d want 1 1", FlushCount, StallCount); end
    $display("test_branch: FlushCount=%0d StallCount=%0d", FlushCount, StallCount);
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    HazardStall = 1'b1; HazardCycles = 2'd3;
    tick();
    HazardStall = 1'b0; HazardCycles = 2'd0;
    #1;
    vectors++; if (Busy !== 1'b1 || StallCount !== 16'd1) begin miscompares++; $display("FAIL mid_pre: got busy=%b stall=%0d want 1 1", Busy, StallCount); end
    Reset = 1'b0;
    #1;
    vectors++; if (PCWrite !== 1'b1 || Busy !== 1'b0 || ControlMux !== 1'b1) begin miscompares++; $display("FAIL mid_abort: got pcw=%b busy=%b cmux=%b want 1 0 1", PCWrite, Busy, ControlMux); end
    vectors++; if (StallCount !== 16'd0) begin miscompares++; $display("FAIL mid_cleared: got %0d want 0", StallCount); end
    Reset = 1'b1;
    tick();
    vectors++; if (PCWrite !== 1'b1 || Busy !== 1'b0 || StallCount !== 16'd0) begin miscompares++; $display("FAIL mid_after: got pcw=%b busy=%b stall=%0d want 1 0 0", PCWrite, Busy, StallCount); end
    $display("test_reset_mid_stall: Busy=%b StallCount=%0d", Busy, StallCount);
  endtask

  task automatic test_saturation();
    do_reset();
    HazardStall = 1'b1; HazardCycles = 2'd1;
    for (int i = 0; i < 20; i++) tick();
    HazardStall = 1'b0;
    #1;
    vectors++; if (stall_count4 !== 4'd15) begin miscompares++; $display("FAIL sat_stall4: got %0d want 15", stall_count4); end
    vectors++; if (StallCount !== 16'd20) begin miscompares++; $display("FAIL sat_stall16: got %0d want 20", StallCount); end
    tick();
    vectors++; if (stall_count4 !== 4'd15) begin miscompares++; $display("FAIL sat_hold4: got %0d want 15", stall_count4); end
    $display("test_saturation: StallCount4=%0d StallCount16=%0d", stall_count4, StallCount);
  endtask

  initial begin
    test_reset();
    test_hazard();
    test_mul();
    test_freeze();
    test_branch();
    test_reset_mid_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Sequences pipeline-register enables, bubbles and flushes for the 5-stage MIPS pipeline.
- Turns single-cycle hazard requests into multi-cycle stalls and holds the front end while a multi-cycle multiply occupies EX.
- Applies a whole-pipeline freeze while data memory is not ready, and flushes IF/ID on taken branches.
- Sits between the combinational hazard detection unit and the PC / IF_ID / ID_EX / EX_MEM / MEM_WB registers; keeps saturating stall and flush statistics.

Parameters:
MUL_LATENCY, 4, EX-occupancy cycles of a multiply including issue cycle (legal 2..7)
CNT_WIDTH, 3, width of internal cycle counter
PERF_WIDTH, 16, width of statistics counters

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous active-low reset
HazardStall  in  1  stall request from hazard detection, valid this cycle
HazardCycles  in  2  bubbles requested with HazardStall (0 treated as 1)
BranchTaken  in  1  branch resolved taken in ID
MulStart  in  1  multiply issued into EX this cycle
DMemStall  in  1  data memory not ready
PCWrite  out  1  PC load enable
IF_ID_Write  out  1  IF/ID load enable
IF_ID_Flush  out  1  clear IF/ID to nop
ControlMux  out  1  1 = pass ID control, 0 = inject bubble into ID/EX
ID_EX_Write  out  1  ID/EX load enable
ExBubble  out  1  inject bubble into EX/MEM
Freeze  out  1  hold EX/MEM and MEM/WB
Busy  out  1  state != RUN
StallCount  out  PERF_WIDTH  cycles with PCWrite=0
FlushCount  out  PERF_WIDTH  cycles with IF_ID_Flush=1

Behaviour:
- States: RUN, HAZ, MUL. Internal counter cnt is CNT_WIDTH bits.
- Reset low, asynchronous: state=RUN, cnt=0, both stats counters=0.
- While Reset is low, outputs are forced regardless of inputs: PCWrite=IF_ID_Write=ID_EX_Write=ControlMux=1; IF_ID_Flush=ExBubble=Freeze=Busy=0.
- Reset asserted mid-stall aborts the stall immediately.
- Default outputs, when no condition below applies: same as the reset values.
- Priority, highest first: DMemStall > MulStart > HazardStall > BranchTaken.
- DMemStall=1, any state:
  - PCWrite=IF_ID_Write=ID_EX_Write=0, Freeze=1; all other outputs at default.
  - state and cnt hold, so pending HAZ/MUL cycles resume after the freeze.
- RUN, MulStart=1:
  - Same cycle: PCWrite=IF_ID_Write=ID_EX_Write=0, ExBubble=1.
  - Next state MUL, cnt=MUL_LATENCY-1.
- RUN, HazardStall=1, no MulStart:
  - Same cycle: PCWrite=IF_ID_Write=0, ControlMux=0.
  - N=max(HazardCycles,1). If N>1, next state HAZ with cnt=N-1; else stay RUN.
- RUN, BranchTaken=1, no other request: IF_ID_Flush=1 same cycle. If suppressed by a higher-priority request, the branch is not remembered.
- HAZ:
  - Outputs as in a RUN hazard stall.
  - Each non-frozen cycle: cnt decrements; when cnt==1 at the edge, next state is RUN.
  - HazardStall, BranchTaken and MulStart are ignored.
  - Total stall length = N cycles.
- MUL:
  - Outputs as in a RUN multiply issue.
  - Same countdown as HAZ; total front-end hold = MUL_LATENCY cycles.
  - All requests except DMemStall are ignored.
- All outputs except the statistics are combinational from state and inputs; statistics are registered.
- StallCount increments at each edge where PCWrite=0 (freeze cycles included). FlushCount increments on IF_ID_Flush=1. Both saturate at all-ones, with no wrap.
- Busy=1 in HAZ or MUL.

Test Plan:
- Reset low with HazardStall=1 → PCWrite=1, ControlMux=1, Busy=0. Release Reset, idle 5 cycles → StallCount=0, FlushCount=0.
- HazardStall=1, HazardCycles=2 for one cycle → PCWrite=0 for exactly 2 cycles, ControlMux=0 both cycles, Busy=1 in cycle 2 only, StallCount=2.
- MulStart=1 one cycle, MUL_LATENCY=4 → PCWrite=ID_EX_Write=0 and ExBubble=1 for 4 cycles; HazardStall pulsed during cycle 2 is ignored.
- MUL entered, DMemStall=1 during cycles 2–4 → Freeze=1 for 3 cycles, ExBubble=0 while frozen; MUL resumes for its remaining 3 cycles; StallCount=7.
- BranchTaken=1 alone → IF_ID_Flush=1 for one cycle, FlushCount=1. BranchTaken with HazardStall=1 → IF_ID_Flush=0, stall taken, FlushCount unchanged.
- Reset pulsed low while in HAZ with cnt=2 → state RUN immediately, PCWrite=1, statistics cleared. PERF_WIDTH=4 with 20 stall cycles → StallCount=15.
